// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window front end.
package conv_pkg;

  // Fill phase holds windows back until kernel_dim-1 full rows are stored.
  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Line buffer depth: kernel_dim-1 full rows plus the kernel_dim newest pixels.
  function automatic int fifo_length(input int width, input int kdim);
    return width * (kdim - 1) + kdim;
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position tracker: row/col plus stride phases and the legal-window flag
// for the pixel currently offered on the input.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int img_width  = 28,
  parameter int img_height = 28,
  parameter int kernel_dim = 3,
  parameter int stride     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  output logic legal,
  output logic fill_done,
  output logic last_pixel
);

  localparam int CW = cnt_w(img_width);
  localparam int RW = cnt_w(img_height);
  localparam int SW = cnt_w(stride);

  localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
  localparam logic [CW-1:0] COL_K    = CW'(kernel_dim - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(kernel_dim - 1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(kernel_dim - 2);
  localparam logic [SW-1:0] PH_LAST  = SW'(stride - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] sx;
  logic [SW-1:0] sy;
  logic          col_wrap;
  logic          row_wrap;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  assign col_wrap = (col == COL_LAST);
  assign row_wrap = (row == ROW_LAST);
  assign col_nxt  = col + CW'(1);
  assign row_nxt  = row + RW'(1);

  // Phases are anchored at the first legal column/row so no divider is needed.
  assign legal      = (col >= COL_K) && (row >= ROW_K) && (sx == '0) && (sy == '0);
  assign fill_done  = col_wrap && (row == ROW_PRE);
  assign last_pixel = col_wrap && row_wrap;

  // Advance the raster position and stride phases on each accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      sx  <= '0;
      sy  <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        sx  <= '0;
        if (row_wrap) begin
          row <= '0;
          sy  <= '0;
        end else begin
          row <= row_nxt;
          if (row_nxt == ROW_K)
            sy <= '0;
          else
            sy <= (sy == PH_LAST) ? '0 : sy + SW'(1);
        end
      end else begin
        col <= col_nxt;
        if (col_nxt == COL_K)
          sx <= '0;
        else
          sx <= (sx == PH_LAST) ? '0 : sx + SW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_buf.sv
// Streaming line buffer presenting a kernel_dim x kernel_dim window of a
// raster-order pixel stream, with stride-aware window valid and backpressure.
module conv_window_buf
  import conv_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int channels      = 1,
  parameter int img_width     = 28,
  parameter int img_height    = 28,
  parameter int kernel_dim    = 3,
  parameter int stride        = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [datatype_size*channels-1:0] i_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [datatype_size*channels-1:0] o_data [kernel_dim*kernel_dim-1:0],
  output logic                              o_frame_done
);

  localparam int PW       = datatype_size * channels;
  localparam int FIFO_LEN = fifo_length(img_width, kernel_dim);

  logic [PW-1:0] sr [FIFO_LEN];
  state_t        state;
  logic          vld_p1;
  logic          frame_done_p1;
  logic          accept;
  logic          legal;
  logic          fill_done;
  logic          last_pixel;
  logic          win_legal;

  // A held window blocks intake; consuming it frees the slot in the same cycle.
  assign o_ready      = !vld_p1 || i_ready;
  assign accept       = i_valid && o_ready;
  assign win_legal    = legal && (state == S_STREAM);
  assign o_valid      = vld_p1;
  assign o_frame_done = frame_done_p1;

  conv_pos_counter #(
    .img_width  (img_width),
    .img_height (img_height),
    .kernel_dim (kernel_dim),
    .stride     (stride)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .legal      (legal),
    .fill_done  (fill_done),
    .last_pixel (last_pixel)
  );

  // Line buffer: entry 0 is the newest pixel, shifts only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_LEN; i++)
        sr[i] <= '0;
    end else if (accept) begin
      sr[0] <= i_data;
      for (int i = 1; i < FIFO_LEN; i++)
        sr[i] <= sr[i-1];
    end
  end

  // Window taps: row offset ky sits img_width entries further back per row.
  for (genvar ky = 0; ky < kernel_dim; ky++) begin : g_ky
    for (genvar kx = 0; kx < kernel_dim; kx++) begin : g_kx
      assign o_data[ky*kernel_dim+kx] = sr[ky*img_width+kx];
    end
  end

  // Fill/stream control with registered window valid and frame-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FILL;
      vld_p1        <= 1'b0;
      frame_done_p1 <= 1'b0;
    end else begin
      frame_done_p1 <= accept && last_pixel && (state == S_STREAM);
      if (accept && win_legal)
        vld_p1 <= 1'b1;
      else if (i_ready)
        vld_p1 <= 1'b0;
      case (state)
        S_FILL:   if (accept && fill_done)  state <= S_STREAM;
        S_STREAM: if (accept && last_pixel) state <= S_FILL;
        default:  state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_buf.sv
// Scoreboard bench: 4x4 two-channel stride-1 instance and 5x5 stride-2 instance.
module tb_conv_window_buf;

  typedef logic [8:0][15:0] win_a_t;
  typedef logic [8:0][7:0]  win_b_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        va_i, ra_o, va_o, ra_i, fda;
  logic [15:0] da_i;
  logic [15:0] da_o [8:0];

  logic        vb_i, rb_o, vb_o, rb_i, fdb;
  logic [7:0]  db_i;
  logic [7:0]  db_o [8:0];

  conv_window_buf #(
    .datatype_size(8), .channels(2), .img_width(4), .img_height(4),
    .kernel_dim(3), .stride(1)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(va_i), .o_ready(ra_o), .i_data(da_i),
    .o_valid(va_o), .i_ready(ra_i), .o_data(da_o), .o_frame_done(fda)
  );

  conv_window_buf #(
    .datatype_size(8), .channels(1), .img_width(5), .img_height(5),
    .kernel_dim(3), .stride(2)
  ) dut_s2 (
    .clk(clk), .rst(rst), .i_valid(vb_i), .o_ready(rb_o), .i_data(db_i),
    .o_valid(vb_o), .i_ready(rb_i), .o_data(db_o), .o_frame_done(fdb)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_win_a = 0, n_win_b = 0, n_fd_a = 0, n_fd_b = 0;
  win_a_t qa[$];
  win_b_t qb[$];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] pix_a(input int p);
    logic [7:0] lo, hi;
    lo = p[7:0];
    hi = lo + 8'd100;
    return {hi, lo};
  endfunction

  // Scoreboard monitors: compare each window at the cycle it is consumed.
  always @(negedge clk) begin
    if (!rst && va_o && ra_i) begin
      win_a_t got, w;
      n_win_a++;
      for (int i = 0; i < 9; i++) got[i] = da_o[i];
      chk("win_a_pending", 144'(qa.size() != 0), 144'(1));
      if (qa.size() != 0) begin
        w = qa.pop_front();
        chk("win_a_data", 144'(got), 144'(w));
      end
    end
    if (!rst && fda) n_fd_a++;
  end

  always @(negedge clk) begin
    if (!rst && vb_o && rb_i) begin
      win_b_t got, w;
      n_win_b++;
      for (int i = 0; i < 9; i++) got[i] = db_o[i];
      chk("win_b_pending", 144'(qb.size() != 0), 144'(1));
      if (qb.size() != 0) begin
        w = qb.pop_front();
        chk("win_b_data", 144'(got), 144'(w));
      end
    end
    if (!rst && fdb) n_fd_b++;
  end

  // Offer one pixel to the 4x4 instance and wait (bounded) for its acceptance.
  task automatic send_a(input int p);
    int n = 0;
    va_i = 1'b1;
    da_i = pix_a(p);
    @(negedge clk);
    while (!ra_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_a_timeout", 144'(0), 144'(1));
    @(posedge clk);
    #1;
    va_i = 1'b0;
    // Legal stride-1 positions in a 4x4 frame with k=3: pixels 10, 11, 14, 15.
    if (p == 10 || p == 11 || p == 14 || p == 15) begin
      win_a_t w;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          w[ky*3+kx] = pix_a(p - ky*4 - kx);
      qa.push_back(w);
    end
  endtask

  task automatic send_b(input int p);
    int n = 0;
    vb_i = 1'b1;
    db_i = p[7:0];
    @(negedge clk);
    while (!rb_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_b_timeout", 144'(0), 144'(1));
    @(posedge clk);
    #1;
    vb_i = 1'b0;
    // Stride 2 in a 5x5 frame: legal at (2,2), (2,4), (4,2), (4,4).
    if (p == 12 || p == 14 || p == 22 || p == 24) begin
      win_b_t w;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          int v;
          v = p - ky*5 - kx;
          w[ky*3+kx] = v[7:0];
        end
      qb.push_back(w);
    end
  endtask

  task automatic run_frame_a(input bit stall);
    for (int p = 0; p < 16; p++) begin
      send_a(p);
      if (p == 10) begin
        chk("first_win_valid", 144'(va_o), 144'(1));
        chk("first_win_d0", 144'(da_o[0]), 144'(16'h6E0A));
        chk("first_win_d8", 144'(da_o[8]), 144'(16'h6400));
        if (stall) begin
          ra_i = 1'b0;
          for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_o_ready", 144'(ra_o), 144'(0));
            chk("stall_d0", 144'(da_o[0]), 144'(16'h6E0A));
            chk("stall_valid", 144'(va_o), 144'(1));
          end
          @(posedge clk);
          #1;
          ra_i = 1'b1;
        end
      end
      if (p == 11) begin
        chk("no_bubble_valid", 144'(va_o), 144'(1));
        chk("no_bubble_d0", 144'(da_o[0]), 144'(16'h6F0B));
      end
      if (p == 15) chk("frame_done_a", 144'(fda), 144'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] orr;
    rst  = 1'b1;
    va_i = 1'b0; ra_i = 1'b1; da_i = '0;
    vb_i = 1'b0; rb_i = 1'b1; db_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    orr = '0;
    for (int i = 0; i < 9; i++) orr |= da_o[i];
    chk("reset_o_valid", 144'(va_o), 144'(0));
    chk("reset_o_ready", 144'(ra_o), 144'(1));
    chk("reset_frame_done", 144'(fda), 144'(0));
    chk("reset_o_data", 144'(orr), 144'(0));
    @(posedge clk);
    #1;

    run_frame_a(1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_frame_a(1'b1);
    repeat (3) @(posedge clk);
    #1;

    for (int p = 0; p < 8; p++) send_a(p);
    rst = 1'b1;
    #1;
    orr = '0;
    for (int i = 0; i < 9; i++) orr |= da_o[i];
    chk("midreset_o_valid", 144'(va_o), 144'(0));
    chk("midreset_o_data", 144'(orr), 144'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame_a(1'b0);
    run_frame_a(1'b0);
    run_frame_a(1'b0);
    repeat (3) @(posedge clk);
    #1;

    for (int p = 0; p < 25; p++) begin
      send_b(p);
      if (p == 24) chk("frame_done_b", 144'(fdb), 144'(1));
    end

    repeat (5) @(negedge clk);
    chk("win_count_a", 144'(n_win_a), 144'(20));
    chk("win_left_a", 144'(qa.size()), 144'(0));
    chk("frame_done_count_a", 144'(n_fd_a), 144'(5));
    chk("win_count_b", 144'(n_win_b), 144'(4));
    chk("win_left_b", 144'(qb.size()), 144'(0));
    chk("frame_done_count_b", 144'(n_fd_b), 144'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
